// File: rtl/gf2m_mul_arb_pkg.sv
// Shared types for the gf2m_mul arbiter: FSM state encoding and a width helper.
package gf2m_mul_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf2m_mul_arb_if.sv
// Requester-side bus of the gf2m_mul arbiter: request levels, packed operands, grant and response.
interface gf2m_mul_arb_if #(
  parameter int NREQ = 4,
  parameter int M    = 83
);
  logic [NREQ-1:0]   req;
  logic [NREQ*M-1:0] req_op_a;
  logic [NREQ*M-1:0] req_op_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [M-1:0]      rsp_data;
  logic              rsp_err;

  modport master (
    output req, req_op_a, req_op_b,
    input  gnt, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req, req_op_a, req_op_b,
    output gnt, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/gf2m_mul_arb_rr_pick.sv
// Combinational round-robin pick: first set req bit after ptr_i, wrapping modulo NREQ.
module gf2m_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    // Walk from the farthest slot back toward ptr+1 so the nearest requester overwrites.
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(ptr_i) + k) % NREQ);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end
endmodule

// File: rtl/gf2m_mul_arb.sv
// Round-robin share of one gf2m_mul: gnt one cycle after req, response one cycle after mul_done.
// Requesters hold req until gnt; define GF2M_ARB_TIMEOUT_EN to bound WAIT at TMO cycles.
module gf2m_mul_arb
  import gf2m_mul_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int M     = 83,
  parameter int DELAY = 7,
  parameter int TMO   = 4 * DELAY
) (
  input  logic          clk,
  input  logic          rst,
  gf2m_mul_arb_if.slave bus,
  output logic          busy,
  output logic          mul_start,
  output logic [M-1:0]  mul_op_a,
  output logic [M-1:0]  mul_op_b,
  input  logic          mul_done,
  input  logic [M-1:0]  mul_op_c
);
  localparam int IW = clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TMO < 1) begin : g_param_chk
    $error("gf2m_mul_arb: NREQ must be 2..8 and TMO positive");
  end

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [M-1:0]    rsp_data_q, rsp_data_d, op_a_q, op_a_d, op_b_q, op_b_d;
  logic            start_q, start_d, busy_q, busy_d;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic [M-1:0]    sel_a, sel_b;

`ifdef GF2M_ARB_TIMEOUT_EN
  localparam int CW = clog2(TMO + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  gf2m_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_a = bus.req_op_a[i*M +: M];
        sel_b = bus.req_op_b[i*M +: M];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    start_d     = 1'b0;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
`ifdef GF2M_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|bus.req) begin
          owner_d = pick_idx;
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          gnt_d   = pick_gnt;
          start_d = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      // mul_done is not looked at here: it may still be held high from the previous product.
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
`ifdef GF2M_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ARB_WAIT: begin
        if (mul_done) begin
          rsp_data_d           = mul_op_c;
          rsp_valid_d[owner_q] = 1'b1;
          ptr_d                = owner_q;
          state_d              = ARB_IDLE;
`ifdef GF2M_ARB_TIMEOUT_EN
          rsp_err_d            = 1'b0;
`endif
        end
`ifdef GF2M_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TMO - 1)) begin
          rsp_data_d           = '0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d            = 1'b1;
          ptr_d                = owner_q;
          state_d              = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= IW'(NREQ - 1);
      owner_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      start_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      busy_q      <= 1'b0;
`ifdef GF2M_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      start_q     <= start_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      busy_q      <= busy_d;
`ifdef GF2M_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = busy_q;
  assign mul_start     = start_q;
  assign mul_op_a      = op_a_q;
  assign mul_op_b      = op_b_q;
endmodule

// File: tb/tb_gf2m_mul_arb.sv
// Bench for gf2m_mul_arb with a fixed-latency stub multiplier whose product is a ^ b.
module tb_gf2m_mul_arb;
  localparam int NREQ  = 4;
  localparam int M     = 83;
  localparam int DELAY = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf2m_mul_arb_if #(.NREQ(NREQ), .M(M)) bus ();
  logic         busy, mul_start, mul_done;
  logic [M-1:0] mul_op_a, mul_op_b, mul_op_c;

  gf2m_mul_arb #(.NREQ(NREQ), .M(M), .DELAY(DELAY)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_op_a  (mul_op_a),
    .mul_op_b  (mul_op_b),
    .mul_done  (mul_done),
    .mul_op_c  (mul_op_c)
  );

  // Stub multiplier: done DELAY cycles after the start cycle; in stale mode done stays up until the next start.
  bit           stale   = 1'b0;
  bit           no_done = 1'b0;
  logic         st_run  = 1'b0;
  logic         st_hold = 1'b0;
  int           st_cnt  = 0;
  logic [M-1:0] st_c    = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      st_run  <= 1'b1;
      st_cnt  <= DELAY - 1;
      st_hold <= 1'b0;
      st_c    <= mul_op_a ^ mul_op_b;
    end else if (st_run && st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
    end else if (st_run) begin
      st_run  <= 1'b0;
      st_hold <= stale;
    end
  end
  assign mul_done = !no_done && ((st_run && st_cnt == 0) || st_hold);
  assign mul_op_c = st_c;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           n_cmp  = 0;
  int           n_bad  = 0;
  int           m_ptr  = NREQ - 1;
  int           t_prev = -100;
  logic [M-1:0] a_m [NREQ];
  logic [M-1:0] b_m [NREQ];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M-1:0] rnd();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[M-1:0];
  endfunction

  // Reference arbitration: first requester after the last served one, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (((int'(r) >> ((p + k) % NREQ)) & 1) == 1) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    bus.req_op_a = {a_m[3], a_m[2], a_m[1], a_m[0]};
    bus.req_op_b = {b_m[3], b_m[2], b_m[1], b_m[0]};
  endtask

  task automatic wait_gnt(input string tag, input int budget, output int t);
    for (int n = 0; n < budget && bus.gnt == '0; n++) tick();
    chk({tag, "_gnt_seen"}, M'(bus.gnt != '0), M'(1));
    t = cyc;
  endtask

  // One full service: grant check, quiet busy window, response DELAY+1 cycles after the grant.
  task automatic do_op(input string tag, input logic [NREQ-1:0] req_after, input bit gap9, input bit poke);
    int           t, w;
    logic [M-1:0] ea;
    wait_gnt(tag, 30, t);
    w = rr_pick(bus.req, m_ptr);
    if (w < 0) w = 0;
    chk({tag, "_gnt"}, M'(bus.gnt), M'(1) << w);
    chk({tag, "_start"}, M'(mul_start), M'(1));
    chk({tag, "_opa"}, mul_op_a, a_m[w]);
    chk({tag, "_opb"}, mul_op_b, b_m[w]);
    chk({tag, "_busy"}, M'(busy), M'(1));
    if (gap9) chk({tag, "_gap"}, M'(t - t_prev), M'(9));
    ea = a_m[w] ^ b_m[w];
    a_m[w] = rnd();
    b_m[w] = rnd();
    drive_ops();
    bus.req = req_after;
    for (int c = 1; c <= DELAY; c++) begin
      if (poke && c == 2) bus.req = req_after | 4'b0010;
      if (poke && c == 6) bus.req = req_after;
      tick();
      chk({tag, "_quiet"}, M'({bus.gnt, bus.rsp_valid, mul_start}), M'(0));
    end
    tick();
    chk({tag, "_rsp_valid"}, M'(bus.rsp_valid), M'(1) << w);
    chk({tag, "_rsp_data"}, bus.rsp_data, ea);
    chk({tag, "_rsp_err"}, M'(bus.rsp_err), M'(0));
    chk({tag, "_idle"}, M'(busy), M'(0));
    m_ptr  = w;
    t_prev = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int              t, w;
    logic [NREQ-1:0] seen;

    bus.req = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_m[i] = rnd();
      b_m[i] = rnd();
    end
    drive_ops();
    repeat (3) tick();
    chk("rst_gnt", M'(bus.gnt), M'(0));
    chk("rst_rsp_valid", M'(bus.rsp_valid), M'(0));
    chk("rst_rsp_data", bus.rsp_data, M'(0));
    chk("rst_rsp_err", M'(bus.rsp_err), M'(0));
    chk("rst_busy", M'(busy), M'(0));
    chk("rst_start", M'(mul_start), M'(0));
    chk("rst_opa", mul_op_a, M'(0));
    chk("rst_opb", mul_op_b, M'(0));
    rst = 1'b0;
    tick();
    chk("idle_busy", M'(busy), M'(0));

    // Single request: 5 * 3 with the xor stub gives 6.
    a_m[1] = M'(5);
    b_m[1] = M'(3);
    drive_ops();
    bus.req = 4'b0010;
    do_op("single", 4'b0000, 1'b0, 1'b0);
    chk("single_data", bus.rsp_data, M'(6));
    tick();
    chk("single_busy_low", M'(busy), M'(0));
    chk("single_pulse", M'(bus.rsp_valid), M'(0));
    chk("single_hold", bus.rsp_data, M'(6));

    // Fairness from reset with every requester asserted.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      a_m[i] = rnd();
      b_m[i] = rnd();
    end
    drive_ops();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) do_op("fair", (k < 4) ? 4'b1111 : 4'b0101, k > 0, 1'b0);

    // Alternation with stale done held through ISSUE and a mid-op request poke.
    stale = 1'b1;
    for (int k = 0; k < 4; k++) do_op("alt", (k < 3) ? 4'b0101 : 4'b0000, 1'b1, k == 1);
    stale = 1'b0;

    // Reset in the fourth WAIT cycle aborts silently.
    a_m[3] = rnd();
    b_m[3] = rnd();
    drive_ops();
    bus.req = 4'b1000;
    wait_gnt("abort", 30, t);
    chk("abort_gnt", M'(bus.gnt), M'(4'b1000));
    bus.req = '0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("abort_gnt0", M'(bus.gnt), M'(0));
    chk("abort_rsp0", M'(bus.rsp_valid), M'(0));
    chk("abort_data0", bus.rsp_data, M'(0));
    chk("abort_busy0", M'(busy), M'(0));
    chk("abort_start0", M'(mul_start), M'(0));
    chk("abort_opa0", mul_op_a, M'(0));
    chk("abort_opb0", mul_op_b, M'(0));
    rst = 1'b0;
    m_ptr = NREQ - 1;
    seen = '0;
    for (int c = 0; c < 15; c++) begin
      tick();
      seen = seen | bus.rsp_valid | bus.gnt;
    end
    chk("abort_silent", M'(seen), M'(0));
    a_m[3] = rnd();
    b_m[3] = rnd();
    drive_ops();
    bus.req = 4'b1000;
    do_op("retry", 4'b0000, 1'b0, 1'b0);

    // Multiplier that never finishes.
    no_done = 1'b1;
    a_m[2] = rnd();
    b_m[2] = rnd();
    drive_ops();
    bus.req = 4'b0100;
    wait_gnt("tmo", 30, t);
    w = rr_pick(bus.req, m_ptr);
    chk("tmo_gnt", M'(bus.gnt), M'(1) << w);
    bus.req = '0;
`ifdef GF2M_ARB_TIMEOUT_EN
    repeat (28) tick();
    chk("tmo_early", M'(bus.rsp_valid), M'(0));
    tick();
    chk("tmo_rsp_valid", M'(bus.rsp_valid), M'(1) << w);
    chk("tmo_rsp_err", M'(bus.rsp_err), M'(1));
    chk("tmo_rsp_data", bus.rsp_data, M'(0));
    chk("tmo_idle", M'(busy), M'(0));
`else
    seen = '0;
    for (int c = 0; c < 100; c++) begin
      tick();
      seen = seen | bus.rsp_valid;
    end
    chk("notmo_silent", M'(seen), M'(0));
    chk("notmo_busy", M'(busy), M'(1));
    chk("notmo_err", M'(bus.rsp_err), M'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
